// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state encoding for the UART transmitter
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic START_BIT_LVL = 1'b0;
  localparam logic STOP_BIT_LVL  = 1'b1;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'd0;
  localparam uart_state_t ST_START = 2'd1;
  localparam uart_state_t ST_DATA  = 2'd2;
  localparam uart_state_t ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO queueing bytes ahead of the serialiser
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [UART_DATA_W-1:0] wr_data_i,
  input  logic                   pop_i,
  output logic [UART_DATA_W-1:0] rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [AW:0]            count_o
);

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]            used;
  logic                   do_push;
  logic                   do_pop;

  // The extra pointer bit separates full (difference == DEPTH) from empty.
  assign used      = wr_ptr_q - rd_ptr_q;
  assign full_o    = (used == DEPTH[AW:0]);
  assign empty_o   = (used == '0);
  assign count_o   = used;
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d  = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter streaming queued bytes back-to-back
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 20_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [UART_DATA_W-1:0]               tx_data,
  input  logic                                 tx_valid,
  output logic                                 tx_ready,
  output logic                                 tx,
  output logic                                 tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

  localparam int          BAUD_DIV  = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  uart_state_t            state_q, state_d;
  logic [15:0]            baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [2:0]             bit_nxt;
  logic [UART_DATA_W-1:0] shift_q, shift_d;
  logic                   tx_q, tx_d;
  logic                   bit_end;
  logic                   pop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] fifo_rd;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (tx_valid),
    .wr_data_i (tx_data),
    .pop_i     (pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign tx_ready = !fifo_full;
  assign tx       = tx_q;
  assign tx_busy  = (state_q != ST_IDLE);
  assign bit_end  = (baud_q == BAUD_LAST);
  assign bit_nxt  = bit_q + 3'd1;

  // tx_d is the level for the cycle after the edge, so the pin stays a pure flop output.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        tx_d   = STOP_BIT_LVL;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd;
          state_d = ST_START;
          tx_d    = START_BIT_LVL;
        end
      end
      ST_START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = STOP_BIT_LVL;
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd;
            state_d = ST_START;
            tx_d    = START_BIT_LVL;
          end else begin
            state_d = ST_IDLE;
            tx_d    = STOP_BIT_LVL;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        tx_d    = STOP_BIT_LVL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT_LVL;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx with scoreboard-driven frame decoding
module tb_uart_tx;

  localparam int DIV_A = 16;
  localparam int DIV_B = 173;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       valid_a = 1'b0, valid_b = 1'b0;
  logic       ready_a, ready_b, tx_a, tx_b, busy_a, busy_b;
  logic [2:0] cnt_a;
  logic [4:0] cnt_b;

  int  n_vec = 0;
  int  n_err = 0;
  bit  mon_en_a = 1'b1;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  uart_tx #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .tx_data(data_a), .tx_valid(valid_a), .tx_ready(ready_a),
    .tx(tx_a), .tx_busy(busy_a), .fifo_count(cnt_a)
  );

  uart_tx u_dut_b (
    .clk(clk), .rst_n(rst_n), .tx_data(data_b), .tx_valid(valid_b), .tx_ready(ready_b),
    .tx(tx_b), .tx_busy(busy_b), .fifo_count(cnt_b)
  );

  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    return fr[pos];
  endfunction

  // Receiver model: entered on the first low sample of a start bit, samples mid-bit.
  task automatic rx_byte(input bit sel, output logic [7:0] b, output logic s0, output logic s1);
    int div;
    div = sel ? DIV_B : DIV_A;
    repeat (div / 2) @(negedge clk);
    s0 = ((sel ? tx_b : tx_a) === 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge clk);
      b[i] = sel ? tx_b : tx_a;
    end
    repeat (div) @(negedge clk);
    s1 = ((sel ? tx_b : tx_a) === 1'b1);
  endtask

  always begin : mon_a
    logic [7:0] b;
    logic [7:0] e;
    logic       s0, s1;
    @(negedge clk);
    if (mon_en_a && rst_n && tx_a === 1'b0) begin
      rx_byte(1'b0, b, s0, s1);
      n_vec++;
      if (exp_a.size() == 0) begin
        n_err++;
        $display("FAIL rx_a_unexpected: got byte %h, required no frame", b);
      end else begin
        e = exp_a.pop_front();
        if ({s0, s1, b} !== {1'b1, 1'b1, e}) begin
          n_err++;
          $display("FAIL rx_a_byte: got %h start_ok=%0b stop_ok=%0b, required %h", b, s0, s1, e);
        end
      end
    end
  end

  always begin : mon_b
    logic [7:0] b;
    logic [7:0] e;
    logic       s0, s1;
    @(negedge clk);
    if (rst_n && tx_b === 1'b0) begin
      rx_byte(1'b1, b, s0, s1);
      n_vec++;
      if (exp_b.size() == 0) begin
        n_err++;
        $display("FAIL rx_b_unexpected: got byte %h, required no frame", b);
      end else begin
        e = exp_b.pop_front();
        if ({s0, s1, b} !== {1'b1, 1'b1, e}) begin
          n_err++;
          $display("FAIL rx_b_byte: got %h start_ok=%0b stop_ok=%0b, required %h", b, s0, s1, e);
        end
      end
    end
  end

  task automatic push(input bit sel, input logic [7:0] b);
    int t;
    t = 0;
    if (sel) begin data_b = b; valid_b = 1'b1; end
    else     begin data_a = b; valid_a = 1'b1; end
    while (!(sel ? ready_b : ready_a) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (t >= 5000) begin
      n_err++;
      $display("FAIL push_timeout: tx_ready stayed 0 for %0d cycles, required 1", t);
      valid_a = 1'b0;
      valid_b = 1'b0;
    end else begin
      @(posedge clk);
      if (sel) exp_b.push_back(b);
      else     exp_a.push_back(b);
      @(negedge clk);
      valid_a = 1'b0;
      valid_b = 1'b0;
    end
  endtask

  task automatic wait_drain(input bit sel);
    int t;
    t = 0;
    while (t < 40000 && (sel ? (busy_b || cnt_b != 5'd0 || exp_b.size() != 0)
                             : (busy_a || cnt_a != 3'd0 || exp_a.size() != 0))) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (t >= 40000) begin
      n_err++;
      $display("FAIL drain_timeout: inst %0d still busy after %0d cycles, required idle", sel, t);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if ({tx_a, busy_a, ready_a, cnt_a} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL reset_a: tx/busy/ready/count=%b%b%b/%0d, required 101/0", tx_a, busy_a, ready_a, cnt_a);
    end
    n_vec++;
    if ({tx_b, busy_b, ready_b, cnt_b} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
      n_err++;
      $display("FAIL reset_b: tx/busy/ready/count=%b%b%b/%0d, required 101/0", tx_b, busy_b, ready_b, cnt_b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic ex_tx, ex_busy;
    wait_drain(1'b0);
    data_a  = 8'h55;
    valid_a = 1'b1;
    @(posedge clk);
    exp_a.push_back(8'h55);
    @(negedge clk);
    valid_a = 1'b0;
    n_vec++;
    if ({tx_a, busy_a, cnt_a} !== {1'b1, 1'b0, 3'd1}) begin
      n_err++;
      $display("FAIL single_push: tx/busy/count=%b%b/%0d, required 10/1", tx_a, busy_a, cnt_a);
    end
    for (int k = 1; k <= 161; k++) begin
      @(negedge clk);
      ex_tx   = (k <= 160) ? frame_bit(8'h55, (k - 1) / DIV_A) : 1'b1;
      ex_busy = (k <= 160);
      n_vec++;
      if ({tx_a, busy_a} !== {ex_tx, ex_busy}) begin
        n_err++;
        $display("FAIL single_line k=%0d: tx/busy=%b%b, required %b%b", k, tx_a, busy_a, ex_tx, ex_busy);
      end
      if (k == 1) begin
        n_vec++;
        if (cnt_a !== 3'd0) begin
          n_err++;
          $display("FAIL single_pop_count: count=%0d, required 0", cnt_a);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[3];
    logic [2:0] cexp[3];
    logic       ex_tx, ex_busy;
    int         c;
    d[0] = 8'hA3; d[1] = 8'h0F; d[2] = 8'hFF;
    cexp[0] = 3'd1; cexp[1] = 3'd1; cexp[2] = 3'd2;
    wait_drain(1'b0);
    n_vec++;
    if (cnt_a !== 3'd0) begin
      n_err++;
      $display("FAIL b2b_count_start: count=%0d, required 0", cnt_a);
    end
    for (int i = 0; i < 3; i++) begin
      data_a  = d[i];
      valid_a = 1'b1;
      @(posedge clk);
      exp_a.push_back(d[i]);
      @(negedge clk);
      n_vec++;
      if (cnt_a !== cexp[i]) begin
        n_err++;
        $display("FAIL b2b_count_push%0d: count=%0d, required %0d", i, cnt_a, cexp[i]);
      end
    end
    valid_a = 1'b0;
    for (int k = 3; k <= 481; k++) begin
      @(negedge clk);
      c       = k - 1;
      ex_tx   = (k <= 480) ? frame_bit(d[c / 160], (c % 160) / DIV_A) : 1'b1;
      ex_busy = (k <= 480);
      n_vec++;
      if ({tx_a, busy_a} !== {ex_tx, ex_busy}) begin
        n_err++;
        $display("FAIL b2b_line k=%0d: tx/busy=%b%b, required %b%b", k, tx_a, busy_a, ex_tx, ex_busy);
      end
      if (k == 161 || k == 321) begin
        n_vec++;
        if (cnt_a !== ((k == 161) ? 3'd1 : 3'd0)) begin
          n_err++;
          $display("FAIL b2b_count k=%0d: count=%0d, required %0d", k, cnt_a, (k == 161) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_fill();
    int acc;
    int t;
    acc = 0;
    t   = 0;
    wait_drain(1'b0);
    data_a  = 8'h10;
    valid_a = 1'b1;
    while (ready_a && acc < 8) begin
      @(posedge clk);
      exp_a.push_back(data_a);
      acc++;
      @(negedge clk);
      data_a = data_a + 8'd1;
    end
    n_vec++;
    if (acc !== 5 || cnt_a !== 3'd4) begin
      n_err++;
      $display("FAIL fill_ready_drop: accepts=%0d count=%0d, required 5 and 4", acc, cnt_a);
    end
    while (acc < 8 && t < 3000) begin
      if (ready_a) begin
        @(posedge clk);
        exp_a.push_back(data_a);
        acc++;
        @(negedge clk);
        data_a = data_a + 8'd1;
      end else begin
        @(negedge clk);
        t++;
      end
    end
    valid_a = 1'b0;
    n_vec++;
    if (acc !== 8) begin
      n_err++;
      $display("FAIL fill_accepts: accepted %0d bytes, required 8", acc);
    end
    wait_drain(1'b0);
  endtask

  task automatic test_push_full();
    wait_drain(1'b0);
    for (int i = 0; i < 5; i++) push(1'b0, 8'hC0 + 8'(i));
    n_vec++;
    if ({ready_a, cnt_a} !== {1'b0, 3'd4}) begin
      n_err++;
      $display("FAIL full_state: ready/count=%b/%0d, required 0/4", ready_a, cnt_a);
    end
    data_a  = 8'hEE;
    valid_a = 1'b1;
    repeat (10) begin
      @(negedge clk);
      n_vec++;
      if ({ready_a, cnt_a} !== {1'b0, 3'd4}) begin
        n_err++;
        $display("FAIL full_ignore: ready/count=%b/%0d, required 0/4", ready_a, cnt_a);
      end
    end
    valid_a = 1'b0;
    wait_drain(1'b0);
  endtask

  task automatic test_reset_mid();
    wait_drain(1'b0);
    mon_en_a = 1'b0;
    data_a   = 8'h00;
    valid_a  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_a = 8'h5A;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    repeat (49) @(negedge clk);
    n_vec++;
    if ({tx_a, busy_a, cnt_a} !== {1'b0, 1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL mid_frame: tx/busy/count=%b%b/%0d, required 01/1", tx_a, busy_a, cnt_a);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({tx_a, busy_a, ready_a, cnt_a} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
      n_err++;
      $display("FAIL async_reset: tx/busy/ready/count=%b%b%b/%0d, required 101/0", tx_a, busy_a, ready_a, cnt_a);
    end
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    @(negedge clk);
    mon_en_a = 1'b1;
    push(1'b0, 8'h96);
    @(negedge clk);
    n_vec++;
    if ({tx_a, busy_a} !== {1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL post_reset_start: tx/busy=%b%b, required 01", tx_a, busy_a);
    end
    wait_drain(1'b0);
  endtask

  task automatic test_loopback();
    for (int i = 0; i < 16; i++) push(1'b1, 8'($urandom_range(0, 255)));
    wait_drain(1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fill();
    test_push_full();
    test_reset_mid();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
